// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst FSM state encoding and a helper that classifies burst-capable modes.
package shift_register_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;
   localparam logic [2:0] MODE_RSVD  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Only shifts and rotates can be repeated by the burst engine.
   function automatic logic is_burst_mode(input logic [2:0] mode);
      return (mode >= MODE_SHL) && (mode <= MODE_ROR);
   endfunction

endpackage

// File: rtl/shift_register_next_value.sv
// Combinational next-value logic for the universal shift register, shared
// by the manual path and the burst engine.
module shift_register_next_value
   import shift_register_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [2:0]            mode_i,
   input  logic [DATA_WIDTH-1:0] reg_i,
   input  logic                  left_i,
   input  logic                  right_i,
   input  logic [DATA_WIDTH-1:0] parallel_i,
   output logic [DATA_WIDTH-1:0] next_o
);

   always_comb begin
      next_o = reg_i;
      case (mode_i)
         MODE_HOLD:  next_o = reg_i;
         MODE_SHL:   next_o = {reg_i[DATA_WIDTH-2:0], right_i};
         MODE_SHR:   next_o = {left_i, reg_i[DATA_WIDTH-1:1]};
         MODE_ROL:   next_o = {reg_i[DATA_WIDTH-2:0], reg_i[DATA_WIDTH-1]};
         MODE_ROR:   next_o = {reg_i[0], reg_i[DATA_WIDTH-1:1]};
         MODE_LOAD:  next_o = parallel_i;
         MODE_CLEAR: next_o = '0;
         default:    next_o = reg_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_register_burst.sv
// N-bit universal shift register with manual per-cycle operation and a burst
// engine that repeats a latched shift/rotate a programmed number of times.
module universal_shift_register_burst
   import shift_register_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
   input  logic                   Clk_In,
   input  logic                   Reset_In,
   input  logic                   Enable_In,
   input  logic [2:0]             Mode_In,
   input  logic [DATA_WIDTH-1:0]  Parallel_Data_In,
   input  logic                   Serial_Data_Left_In,
   input  logic                   Serial_Data_Right_In,
   input  logic                   Start_In,
   input  logic [COUNT_WIDTH-1:0] Burst_Length_In,
   output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
   output logic                   Serial_Data_Msb_Out,
   output logic                   Serial_Data_Lsb_Out,
   output logic                   Busy_Out,
   output logic                   Done_Out
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  reg_q, reg_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [2:0]             op_q, op_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [2:0]             op_sel_s;
   logic [DATA_WIDTH-1:0]  next_s;

   assign op_sel_s = (state_q == ST_BURST) ? op_q : Mode_In;

   shift_register_next_value #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_next (
      .mode_i     (op_sel_s),
      .reg_i      (reg_q),
      .left_i     (Serial_Data_Left_In),
      .right_i    (Serial_Data_Right_In),
      .parallel_i (Parallel_Data_In),
      .next_o     (next_s)
   );

   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      count_d = count_q;
      op_d    = op_q;
      busy_d  = busy_q;
      done_d  = done_q;
      if (Enable_In) begin
         case (state_q)
            ST_IDLE: begin
               if (Start_In && is_burst_mode(Mode_In)) begin
                  op_d = Mode_In;
                  if (Burst_Length_In == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_BURST;
                     busy_d  = 1'b1;
                     count_d = Burst_Length_In;
                  end
               end else begin
                  reg_d = next_s;
               end
            end
            ST_BURST: begin
               reg_d   = next_s;
               count_d = count_q - COUNT_WIDTH'(1);
               // The step applied with count 1 is the last one.
               if (count_q == COUNT_WIDTH'(1)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_BURST;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(negedge Clk_In) begin
      if (Reset_In) begin
         state_q <= ST_IDLE;
         reg_q   <= '0;
         count_q <= '0;
         op_q    <= MODE_HOLD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         count_q <= count_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Parallel_Data_Out   = reg_q;
   assign Busy_Out            = busy_q;
   assign Done_Out            = done_q;
   assign Serial_Data_Msb_Out = Enable_In ? reg_q[DATA_WIDTH-1] : 1'bz;
   assign Serial_Data_Lsb_Out = Enable_In ? reg_q[0] : 1'bz;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Self-checking bench for universal_shift_register_burst (DATA_WIDTH = 8):
// vector table through a scoreboard queue, plus long-burst sequences.
module tb_universal_shift_register_burst;
   import shift_register_pkg::*;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b1;
   logic [2:0]    mode = MODE_HOLD;
   logic [DW-1:0] pd = '0;
   logic          left = 1'b0;
   logic          right = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic [DW-1:0] pout;
   wire           msb_w;
   wire           lsb_w;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   pullup (msb_w);
   pullup (lsb_w);

   always #5 clk = ~clk;

   universal_shift_register_burst #(.DATA_WIDTH(DW)) dut (
      .Clk_In               (clk),
      .Reset_In             (rst),
      .Enable_In            (en),
      .Mode_In              (mode),
      .Parallel_Data_In     (pd),
      .Serial_Data_Left_In  (left),
      .Serial_Data_Right_In (right),
      .Start_In             (start),
      .Burst_Length_In      (len),
      .Parallel_Data_Out    (pout),
      .Serial_Data_Msb_Out  (msb_w),
      .Serial_Data_Lsb_Out  (lsb_w),
      .Busy_Out             (busy),
      .Done_Out             (done)
   );

   typedef struct {
      logic          rst, en, start;
      logic [2:0]    mode;
      logic [DW-1:0] pd;
      logic          left, right;
      logic [CW-1:0] len;
      logic [DW-1:0] er;
      logic          eb, ed;
   } vec_t;

   typedef struct {
      int            idx;
      logic [DW-1:0] r;
      logic          b, d, msb, lsb;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(logic r_, logic e_, logic s_, logic [2:0] m_, logic [7:0] p_,
                               logic l_, logic rt_, logic [3:0] n_, logic [7:0] er_,
                               logic eb_, logic ed_);
      vec_t v;
      v.rst = r_; v.en = e_; v.start = s_; v.mode = m_; v.pd = p_;
      v.left = l_; v.right = rt_; v.len = n_; v.er = er_; v.eb = eb_; v.ed = ed_;
      return v;
   endfunction

   // Active edge is the falling edge; sample and drive at the rising edge.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic cmp(string nm, int idx, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic run_burst(string nm, logic [2:0] m, logic [3:0] n, logic [7:0] init,
                            logic r_in, logic [7:0] expv);
      int nb;
      int cyc;
      mode = MODE_LOAD; pd = init; start = 1'b0; right = r_in; left = 1'b0;
      tick();
      cmp({nm, "_load"}, 0, pout, init);
      mode = m; len = n; start = 1'b1;
      tick();
      start = 1'b0; mode = MODE_HOLD;
      nb = 0; cyc = 0;
      while (!done && cyc < 40) begin
         if (busy) nb++;
         tick();
         cyc++;
      end
      cmp({nm, "_timeout"}, cyc, {7'd0, done}, 8'd1);
      cmp({nm, "_busycnt"}, 0, 8'(nb), 8'(n));
      cmp({nm, "_busy_at_done"}, 0, {7'd0, busy}, 8'd0);
      cmp({nm, "_value"}, 0, pout, expv);
      tick();
      cmp({nm, "_done_clr"}, 0, {7'd0, done}, 8'd0);
   endtask

   initial begin
      exp_t e;
      // rst en st mode pd l r len | reg busy done
      tbl.push_back(mk(1,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h00,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'hA5,0,0,4'd0, 8'hA5,0,0));
      tbl.push_back(mk(1,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h00,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'h81,0,0,4'd0, 8'h81,0,0));
      tbl.push_back(mk(0,1,0,MODE_SHL  ,8'h00,0,1,4'd0, 8'h03,0,0));
      tbl.push_back(mk(0,1,0,MODE_ROR  ,8'h00,0,0,4'd0, 8'h81,0,0));
      tbl.push_back(mk(0,1,0,MODE_SHR  ,8'h00,0,0,4'd0, 8'h40,0,0));
      tbl.push_back(mk(0,1,0,MODE_CLEAR,8'h00,0,0,4'd0, 8'h00,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'h96,0,0,4'd0, 8'h96,0,0));
      tbl.push_back(mk(0,1,1,MODE_ROL  ,8'h00,0,0,4'd3, 8'h96,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h2D,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h5A,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'hB4,0,1));
      tbl.push_back(mk(0,1,1,MODE_ROL  ,8'h00,0,0,4'd3, 8'hB4,0,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'hB4,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'h96,0,0,4'd0, 8'h96,0,0));
      tbl.push_back(mk(0,1,1,MODE_ROL  ,8'h00,0,0,4'd8, 8'h96,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h2D,1,0));
      tbl.push_back(mk(0,1,1,MODE_LOAD ,8'hFF,0,0,4'd1, 8'h5A,1,0));
      tbl.push_back(mk(0,1,0,MODE_SHR  ,8'h00,0,0,4'd0, 8'hB4,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h69,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'hD2,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'hA5,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h4B,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h96,0,1));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h96,0,0));
      tbl.push_back(mk(0,1,1,MODE_ROL  ,8'h00,0,0,4'd0, 8'h96,0,1));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h96,0,0));
      tbl.push_back(mk(0,1,1,MODE_LOAD ,8'h3C,0,0,4'd5, 8'h3C,0,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h3C,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'hF0,0,0,4'd0, 8'hF0,0,0));
      tbl.push_back(mk(0,1,1,MODE_SHR  ,8'h00,0,0,4'd4, 8'hF0,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h78,1,0));
      tbl.push_back(mk(0,0,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h78,1,0));
      tbl.push_back(mk(0,0,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h78,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h3C,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h1E,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h0F,0,1));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,0,4'd0, 8'h0F,0,0));
      tbl.push_back(mk(0,1,0,MODE_LOAD ,8'h55,0,0,4'd0, 8'h55,0,0));
      tbl.push_back(mk(0,1,1,MODE_SHL  ,8'h00,0,1,4'd5, 8'h55,1,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,1,4'd0, 8'hAB,1,0));
      tbl.push_back(mk(1,1,0,MODE_HOLD ,8'h00,0,1,4'd0, 8'h00,0,0));
      tbl.push_back(mk(0,1,0,MODE_HOLD ,8'h00,0,1,4'd0, 8'h00,0,0));
      tbl.push_back(mk(0,1,0,MODE_SHL  ,8'h00,0,1,4'd0, 8'h01,0,0));
      tbl.push_back(mk(0,1,0,MODE_RSVD ,8'hFF,0,1,4'd0, 8'h01,0,0));
      tbl.push_back(mk(0,0,0,MODE_LOAD ,8'hFF,0,0,4'd0, 8'h01,0,0));

      @(posedge clk);
      foreach (tbl[i]) begin
         rst = tbl[i].rst; en = tbl[i].en; start = tbl[i].start; mode = tbl[i].mode;
         pd = tbl[i].pd; left = tbl[i].left; right = tbl[i].right; len = tbl[i].len;
         e.idx = i; e.r = tbl[i].er; e.b = tbl[i].eb; e.d = tbl[i].ed;
         // Pull-ups make a released serial output read as 1.
         e.msb = tbl[i].en ? tbl[i].er[DW-1] : 1'b1;
         e.lsb = tbl[i].en ? tbl[i].er[0]    : 1'b1;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         cmp("reg",  e.idx, pout, e.r);
         cmp("busy", e.idx, {7'd0, busy}, {7'd0, e.b});
         cmp("done", e.idx, {7'd0, done}, {7'd0, e.d});
         cmp("msb",  e.idx, {7'd0, msb_w}, {7'd0, e.msb});
         cmp("lsb",  e.idx, {7'd0, lsb_w}, {7'd0, e.lsb});
         cmp("excl", e.idx, {7'd0, busy & done}, 8'd0);
      end

      rst = 1'b0; en = 1'b1;
      run_burst("shl10", MODE_SHL, 4'd10, 8'h00, 1'b1, 8'hFF);
      run_burst("ror11", MODE_ROR, 4'd11, 8'h01, 1'b0, 8'h20);
      run_burst("rol15", MODE_ROL, 4'd15, 8'h96, 1'b0, 8'h4B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
